// File: rtl/coreaxitoahbl_pkg.sv
// rtl/coreaxitoahbl_pkg.sv - shared encodings and payload field layout for the AXI-to-AHB-Lite bridge
//
// Contents:
//   skid_state_t   per-channel skid buffer occupancy (EMPTY / ONE / TWO)
//   field widths   fixed AXI3 control field widths (LEN, SIZE, BURST)
//   field offsets  LSB positions of the fixed fields inside the packed
//                  AW/AR and W payloads; ID/ADDR/DATA positions follow from
//                  the top-level width parameters.
package coreaxitoahbl_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;

    // Address-channel payload {ID, ADDR, LEN, SIZE, BURST}, LSB first.
    localparam int AX_CTRL_W    = LEN_W + SIZE_W + BURST_W;
    localparam int AX_BURST_LSB = 0;
    localparam int AX_SIZE_LSB  = AX_BURST_LSB + BURST_W;
    localparam int AX_LEN_LSB   = AX_SIZE_LSB + SIZE_W;
    localparam int AX_ADDR_LSB  = AX_LEN_LSB + LEN_W;

    // Write-data payload {ID, DATA, STRB, LAST}, LSB first.
    localparam int W_LAST_LSB = 0;
    localparam int W_STRB_LSB = 1;

endpackage

// File: rtl/coreaxitoahbl_skid_buf.sv
// rtl/coreaxitoahbl_skid_buf.sv - two-entry registered skid buffer for one valid/ready channel
//
// Ports:
//   ACLK, ARESETN           clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     upstream (master) side; in_ready is a flop
//   out_valid/out_ready/out_data  downstream (controller) side; out_valid and
//                                 out_data are flops
module coreaxitoahbl_skid_buf
    import coreaxitoahbl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state;
    skid_state_t      next_state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             pop;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = main_q;

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    next_state   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    next_state = ST_TWO;
                end else if (pop) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    load_main_skid = 1'b1;
                    next_state     = ST_ONE;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    // in_ready and out_valid are registered copies of decodes of next_state,
    // so neither side sees combinational logic on these handshakes.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != ST_TWO);
            out_valid <= (next_state != ST_EMPTY);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/coreaxitoahbl_axi_in_skid.sv
// rtl/coreaxitoahbl_axi_in_skid.sv - registered AXI slave input stage (AW, W, AR skid buffers)
//
// Ports:
//   ACLK, ARESETN                  clock, asynchronous active-low reset
//   AW*/W*/AR* master fields       inbound AXI3 channel payloads and VALIDs
//   AWREADY/WREADY/ARREADY         registered READYs back to the master
//   AWPayloadOut/WPayloadOut/ARPayloadOut  packed payloads to the slave controller
//   AWVALIDOut/WVALIDOut/ARVALIDOut        registered VALIDs to the controller
//   AWREADYIn/WREADYIn/ARREADYIn           controller READYs
module coreaxitoahbl_axi_in_skid
    import coreaxitoahbl_pkg::*;
#(
    parameter int ID_WIDTH      = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int AXI_DWIDTH    = 64,
    parameter int AXI_STRBWIDTH = 8,
    localparam int AW_PL_W      = ID_WIDTH + ADDR_WIDTH + AX_CTRL_W,
    localparam int W_PL_W       = ID_WIDTH + AXI_DWIDTH + AXI_STRBWIDTH + 1,
    localparam int AR_PL_W      = AW_PL_W
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [ID_WIDTH-1:0]      AWID,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic [LEN_W-1:0]         AWLEN,
    input  logic [SIZE_W-1:0]        AWSIZE,
    input  logic [BURST_W-1:0]       AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [ID_WIDTH-1:0]      WID,
    input  logic [AXI_DWIDTH-1:0]    WDATA,
    input  logic [AXI_STRBWIDTH-1:0] WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [ID_WIDTH-1:0]      ARID,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,
    input  logic [LEN_W-1:0]         ARLEN,
    input  logic [SIZE_W-1:0]        ARSIZE,
    input  logic [BURST_W-1:0]       ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [AW_PL_W-1:0]       AWPayloadOut,
    output logic [W_PL_W-1:0]        WPayloadOut,
    output logic [AR_PL_W-1:0]       ARPayloadOut,
    output logic                     AWVALIDOut,
    output logic                     WVALIDOut,
    output logic                     ARVALIDOut,
    input  logic                     AWREADYIn,
    input  logic                     WREADYIn,
    input  logic                     ARREADYIn
);

    localparam int AX_ID_LSB  = AX_ADDR_LSB + ADDR_WIDTH;
    localparam int W_DATA_LSB = W_STRB_LSB + AXI_STRBWIDTH;
    localparam int W_ID_LSB   = W_DATA_LSB + AXI_DWIDTH;

    logic [AW_PL_W-1:0] aw_pl;
    logic [W_PL_W-1:0]  w_pl;
    logic [AR_PL_W-1:0] ar_pl;

    always_comb begin
        aw_pl = '0;
        aw_pl[AX_BURST_LSB +: BURST_W]  = AWBURST;
        aw_pl[AX_SIZE_LSB  +: SIZE_W]   = AWSIZE;
        aw_pl[AX_LEN_LSB   +: LEN_W]    = AWLEN;
        aw_pl[AX_ADDR_LSB  +: ADDR_WIDTH] = AWADDR;
        aw_pl[AX_ID_LSB    +: ID_WIDTH] = AWID;

        ar_pl = '0;
        ar_pl[AX_BURST_LSB +: BURST_W]  = ARBURST;
        ar_pl[AX_SIZE_LSB  +: SIZE_W]   = ARSIZE;
        ar_pl[AX_LEN_LSB   +: LEN_W]    = ARLEN;
        ar_pl[AX_ADDR_LSB  +: ADDR_WIDTH] = ARADDR;
        ar_pl[AX_ID_LSB    +: ID_WIDTH] = ARID;

        w_pl = '0;
        w_pl[W_LAST_LSB]                  = WLAST;
        w_pl[W_STRB_LSB +: AXI_STRBWIDTH] = WSTRB;
        w_pl[W_DATA_LSB +: AXI_DWIDTH]    = WDATA;
        w_pl[W_ID_LSB   +: ID_WIDTH]      = WID;
    end

    coreaxitoahbl_skid_buf #(.WIDTH(AW_PL_W)) u_aw_skid (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .in_valid  (AWVALID),
        .in_ready  (AWREADY),
        .in_data   (aw_pl),
        .out_valid (AWVALIDOut),
        .out_ready (AWREADYIn),
        .out_data  (AWPayloadOut)
    );

    coreaxitoahbl_skid_buf #(.WIDTH(W_PL_W)) u_w_skid (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .in_valid  (WVALID),
        .in_ready  (WREADY),
        .in_data   (w_pl),
        .out_valid (WVALIDOut),
        .out_ready (WREADYIn),
        .out_data  (WPayloadOut)
    );

    coreaxitoahbl_skid_buf #(.WIDTH(AR_PL_W)) u_ar_skid (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .in_valid  (ARVALID),
        .in_ready  (ARREADY),
        .in_data   (ar_pl),
        .out_valid (ARVALIDOut),
        .out_ready (ARREADYIn),
        .out_data  (ARPayloadOut)
    );

endmodule

// File: tb/tb_coreaxitoahbl_axi_in_skid.sv
// tb/tb_coreaxitoahbl_axi_in_skid.sv - directed self-checking bench for coreaxitoahbl_axi_in_skid
module tb_coreaxitoahbl_axi_in_skid;

    logic        ACLK;
    logic        ARESETN;
    logic [3:0]  AWID, WID, ARID;
    logic [31:0] AWADDR, ARADDR;
    logic [3:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        AWVALID, WVALID, ARVALID;
    logic        AWREADY, WREADY, ARREADY;
    logic [44:0] AWPayloadOut;
    logic [76:0] WPayloadOut;
    logic [44:0] ARPayloadOut;
    logic        AWVALIDOut, WVALIDOut, ARVALIDOut;
    logic        AWREADYIn, WREADYIn, ARREADYIn;

    int n_assert = 0;
    int n_fail   = 0;

    coreaxitoahbl_axi_in_skid dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .AWID         (AWID),
        .AWADDR       (AWADDR),
        .AWLEN        (AWLEN),
        .AWSIZE       (AWSIZE),
        .AWBURST      (AWBURST),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .WID          (WID),
        .WDATA        (WDATA),
        .WSTRB        (WSTRB),
        .WLAST        (WLAST),
        .WVALID       (WVALID),
        .WREADY       (WREADY),
        .ARID         (ARID),
        .ARADDR       (ARADDR),
        .ARLEN        (ARLEN),
        .ARSIZE       (ARSIZE),
        .ARBURST      (ARBURST),
        .ARVALID      (ARVALID),
        .ARREADY      (ARREADY),
        .AWPayloadOut (AWPayloadOut),
        .WPayloadOut  (WPayloadOut),
        .ARPayloadOut (ARPayloadOut),
        .AWVALIDOut   (AWVALIDOut),
        .WVALIDOut    (WVALIDOut),
        .ARVALIDOut   (ARVALIDOut),
        .AWREADYIn    (AWREADYIn),
        .WREADYIn     (WREADYIn),
        .ARREADYIn    (ARREADYIn)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [44:0] awp(input logic [31:0] addr);
        return {4'd1, addr, 4'd3, 3'd2, 2'd1};
    endfunction

    function automatic logic [44:0] arp(input logic [31:0] addr);
        return {4'd5, addr, 4'd0, 3'd3, 2'd1};
    endfunction

    function automatic logic [76:0] wp(input logic [63:0] data, input logic last);
        return {4'd2, data, 8'hFF, last};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        AWID = 4'd1; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'd1; AWADDR = '0;
        ARID = 4'd5; ARLEN = 4'd0; ARSIZE = 3'd3; ARBURST = 2'd1; ARADDR = '0;
        WID = 4'd2; WSTRB = 8'hFF; WDATA = '0; WLAST = 1'b0;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        AWREADYIn = 1'b0; WREADYIn = 1'b0; ARREADYIn = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_awvalid", AWVALIDOut, 0);
        chk("rst_wvalid", WVALIDOut, 0);
        chk("rst_arvalid", ARVALIDOut, 0);
        chk("rst_awpl", AWPayloadOut, 0);
        chk("rst_wpl", WPayloadOut, 0);
        chk("rst_arpl", ARPayloadOut, 0);

        // Release: READYs rise on the first edge, VALIDOuts stay low
        ARESETN = 1'b1;
        chk("rel_awready_pre", AWREADY, 0);
        tick();
        chk("rel_awready", AWREADY, 1);
        chk("rel_wready", WREADY, 1);
        chk("rel_arready", ARREADY, 1);
        chk("rel_awvalid", AWVALIDOut, 0);
        chk("rel_wvalid", WVALIDOut, 0);
        chk("rel_arvalid", ARVALIDOut, 0);

        // AW streaming, 4 beats, controller always ready
        AWREADYIn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            AWVALID = 1'b1;
            AWADDR  = 32'h100 + 32'(4 * k);
            tick();
            chk($sformatf("aw_stream_valid%0d", k), AWVALIDOut, 1);
            chk($sformatf("aw_stream_pl%0d", k), AWPayloadOut, awp(32'h100 + 32'(4 * k)));
            chk($sformatf("aw_stream_ready%0d", k), AWREADY, 1);
        end
        AWVALID = 1'b0;
        AWADDR  = 32'hDEAD;
        tick();
        chk("aw_stream_end_valid", AWVALIDOut, 0);

        // W stall: A1 lands, READYIn low for 3 cycles, one extra beat goes to skid
        WVALID = 1'b1; WDATA = 64'hA1; WLAST = 1'b0; WREADYIn = 1'b0;
        tick();
        chk("w_st1_valid", WVALIDOut, 1);
        chk("w_st1_pl", WPayloadOut, wp(64'hA1, 1'b0));
        chk("w_st1_ready", WREADY, 1);
        WDATA = 64'hA2;
        tick();
        chk("w_st2_ready", WREADY, 0);
        chk("w_st2_pl", WPayloadOut, wp(64'hA1, 1'b0));
        WDATA = 64'hA3;
        tick();
        chk("w_st3_ready", WREADY, 0);
        chk("w_st3_pl", WPayloadOut, wp(64'hA1, 1'b0));
        // Drain from TWO with WVALID still high: READY back with no bubble
        WREADYIn = 1'b1;
        tick();
        chk("w_dr1_pl", WPayloadOut, wp(64'hA2, 1'b0));
        chk("w_dr1_ready", WREADY, 1);
        chk("w_dr1_valid", WVALIDOut, 1);
        tick();
        chk("w_dr2_pl", WPayloadOut, wp(64'hA3, 1'b0));
        WDATA = 64'hA4; WLAST = 1'b1;
        tick();
        chk("w_dr3_pl", WPayloadOut, wp(64'hA4, 1'b1));
        WVALID = 1'b0; WLAST = 1'b0;
        tick();
        chk("w_dr4_valid", WVALIDOut, 0);
        chk("w_dr4_ready", WREADY, 1);

        // Independence: AR stalled into TWO while AW and W stream 8 beats
        ARREADYIn = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ARVALID = 1'b1;
            ARADDR  = (k == 0) ? 32'h200 : (k == 1) ? 32'h204 : 32'h208;
            AWVALID = 1'b1;
            AWADDR  = 32'h300 + 32'(4 * k);
            WVALID  = 1'b1;
            WDATA   = 64'hB0 + 64'(k);
            tick();
            chk($sformatf("ind_aw_pl%0d", k), AWPayloadOut, awp(32'h300 + 32'(4 * k)));
            chk($sformatf("ind_aw_valid%0d", k), AWVALIDOut, 1);
            chk($sformatf("ind_w_pl%0d", k), WPayloadOut, wp(64'hB0 + 64'(k), 1'b0));
            chk($sformatf("ind_w_ready%0d", k), WREADY, 1);
        end
        chk("ind_ar_valid", ARVALIDOut, 1);
        chk("ind_ar_pl", ARPayloadOut, arp(32'h200));
        chk("ind_ar_ready", ARREADY, 0);

        // Reset mid-burst with AR in TWO and AW/W busy: everything clears at once
        ARESETN = 1'b0;
        #1;
        chk("mrst_arvalid", ARVALIDOut, 0);
        chk("mrst_awvalid", AWVALIDOut, 0);
        chk("mrst_wvalid", WVALIDOut, 0);
        chk("mrst_arready", ARREADY, 0);
        chk("mrst_awready", AWREADY, 0);
        chk("mrst_wready", WREADY, 0);
        chk("mrst_arpl", ARPayloadOut, 0);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        tick();
        ARESETN = 1'b1;
        tick();
        chk("post_arready", ARREADY, 1);
        chk("post_arvalid", ARVALIDOut, 0);
        chk("post_arpl", ARPayloadOut, 0);
        ARREADYIn = 1'b1;
        ARVALID   = 1'b1;
        ARADDR    = 32'h400;
        tick();
        chk("post_ar_new_pl", ARPayloadOut, arp(32'h400));
        chk("post_ar_new_valid", ARVALIDOut, 1);
        ARVALID = 1'b0;
        tick();
        chk("post_ar_no_stale", ARVALIDOut, 0);
        chk("post_ar_ready", ARREADY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
